// File: rtl/mem_bank_pkg.sv
// rtl/mem_bank_pkg.sv - shared types and helpers for the SRAM bank
// Contents: FSM state enum, word-offset / index-width helpers, latency limit.
package mem_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    localparam int LATENCY_MAX = 15;

    // Number of byte-offset bits below the word index.
    function automatic int off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Number of word-index bits for a bank of the given depth.
    function automatic int idx_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_sram_bank_if.sv
// rtl/mem_sram_bank_if.sv - mem_* request interface between bus slave and SRAM bank
// Signals: mem_addr, mem_wdata, mem_wstrb, mem_wen, mem_ren (master -> bank);
//          mem_rdata, mem_ready (bank -> master).
// Modports: master (requester), slave (bank).
interface mem_sram_bank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic                    mem_wen;
    logic                    mem_ren;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_wstrb, mem_wen, mem_ren,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wstrb, mem_wen, mem_ren,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_sram_array.sv
// rtl/mem_sram_array.sv - single-port synchronous RAM, byte write enables, registered read
// Ports: clk; en (access strobe); we (1 = write, 0 = read); idx (word index);
//        wdata/wstrb (write data and byte enables); rdata (registered read data,
//        updated only by a read, held otherwise).
// Storage only, so it can be replaced by a vendor RAM macro with the same behaviour.
module mem_sram_array
    import mem_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int IDX_W     = idx_bits(DEPTH),
    localparam int SW        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [SW-1:0]         wstrb,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < SW; b++) begin
                    if (wstrb[b]) begin
                        mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_sram_bank.sv
// rtl/mem_sram_bank.sv - word-organised SRAM bank behind the mem_* request interface
// Ports: clk; rst (synchronous, active-high); bus (mem_sram_bank_if.slave);
//        bank_busy (high while waiting out LATENCY or clearing).
// Optional feature: MEM_SRAM_BANK_INIT_CLEAR_EN zero-fills the array after reset.
module mem_sram_bank
    import mem_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_sram_bank_if.slave       bus,
    output logic                 bank_busy
);

    localparam int OFF   = off_bits(DATA_WIDTH);
    localparam int IDX_W = idx_bits(DEPTH);
    localparam int SW    = DATA_WIDTH / 8;
    localparam int CW    = 4;

`ifdef MEM_SRAM_BANK_INIT_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic                  op_wr_q, op_wr_d;
    logic                  ready_q, ready_d;
    logic                  rd_seen_q, rd_seen_d;
`ifdef MEM_SRAM_BANK_INIT_CLEAR_EN
    logic [IDX_W-1:0]      clr_q, clr_d;
`endif

    logic                  do_access;
    logic                  arr_en, arr_we;
    logic [IDX_W-1:0]      arr_idx;
    logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;
    logic [SW-1:0]         arr_wstrb;
    logic                  req;

    assign req = bus.mem_wen | bus.mem_ren;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        op_wr_d   = op_wr_q;
        ready_d   = ready_q;
        rd_seen_d = rd_seen_q;
`ifdef MEM_SRAM_BANK_INIT_CLEAR_EN
        clr_d     = clr_q;
`endif
        do_access = 1'b0;
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_idx   = idx_q;
        arr_wdata = wdata_q;
        arr_wstrb = wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d   = bus.mem_addr[OFF+IDX_W-1:OFF];
                    wdata_d = bus.mem_wdata;
                    wstrb_d = bus.mem_wstrb;
                    op_wr_d = bus.mem_wen;     // write wins when both are raised
                    cnt_d   = CW'(LATENCY);
                    if (LATENCY == 0) begin
                        do_access = 1'b1;
                        ready_d   = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // cnt_q counts the wait cycles still to run, this one included,
                // so the access fires on the edge closing the last wait cycle.
                if (cnt_q <= CW'(1)) begin
                    cnt_d     = '0;
                    do_access = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                if (!req) begin
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
`ifdef MEM_SRAM_BANK_INIT_CLEAR_EN
            ST_CLEAR: begin
                arr_en    = 1'b1;
                arr_we    = 1'b1;
                arr_idx   = clr_q;
                arr_wdata = '0;
                arr_wstrb = '1;
                clr_d     = clr_q + IDX_W'(1);
                if (clr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (do_access) begin
            arr_en    = 1'b1;
            arr_we    = op_wr_d;
            arr_idx   = idx_d;
            arr_wdata = wdata_d;
            arr_wstrb = wstrb_d;
            rd_seen_d = rd_seen_q | ~op_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            op_wr_q   <= 1'b0;
            ready_q   <= 1'b0;
            rd_seen_q <= 1'b0;
`ifdef MEM_SRAM_BANK_INIT_CLEAR_EN
            clr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            op_wr_q   <= op_wr_d;
            ready_q   <= ready_d;
            rd_seen_q <= rd_seen_d;
`ifdef MEM_SRAM_BANK_INIT_CLEAR_EN
            clr_q     <= clr_d;
`endif
        end
    end

    // Gating with rst drops an access that coincides with reset.
    mem_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (arr_en & ~rst),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .wstrb (arr_wstrb),
        .rdata (arr_rdata)
    );

    // The RAM output register has no reset; present zero until the first read.
    assign bus.mem_rdata = rd_seen_q ? arr_rdata : '0;
    assign bus.mem_ready = ready_q;
    assign bank_busy     = (state_q == ST_WAIT) || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mem_sram_bank.sv
// tb/tb_mem_sram_bank.sv - self-checking bench for mem_sram_bank (LATENCY 1 and 4 instances)
module tb_mem_sram_bank;
    import mem_bank_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic        wen   [2];
    logic        ren   [2];
    logic        busy0, busy1;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [2][1024];

    mem_sram_bank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    mem_sram_bank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();

    assign if0.mem_addr  = addr[0];
    assign if0.mem_wdata = wdata[0];
    assign if0.mem_wstrb = wstrb[0];
    assign if0.mem_wen   = wen[0];
    assign if0.mem_ren   = ren[0];
    assign if1.mem_addr  = addr[1];
    assign if1.mem_wdata = wdata[1];
    assign if1.mem_wstrb = wstrb[1];
    assign if1.mem_wen   = wen[1];
    assign if1.mem_ren   = ren[1];

    mem_sram_bank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .LATENCY(1)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .bank_busy(busy0)
    );
    mem_sram_bank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .LATENCY(4)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .bank_busy(busy1)
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction
    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? if0.mem_rdata : if1.mem_rdata;
    endfunction
    function automatic logic get_ready(input int d);
        return (d == 0) ? if0.mem_ready : if1.mem_ready;
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] data,
                               input logic [3:0] st);
        int i;
        i = int'(a[11:2]);
        for (int b = 0; b < 4; b++) begin
            if (st[b]) model[d][i][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    // One complete request: drive, wait for ready, hold, withdraw, see ready fall.
    task automatic access(input int d, input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st, input int hold);
        int n;
        logic got;
        logic [31:0] prev, held, e;
        @(posedge clk); #1;
        prev     = get_rdata(d);
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = st;
        wen[d]   = wr;
        ren[d]   = rd;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (get_ready(d)) got = 1'b1;
            else chk("busy_window", 32'(get_busy(d)), 32'((n >= 2) && (n <= lat(d) + 1)));
        end
        chk("ready_latency", n, lat(d) + 2);
        if (got) begin
            if (rd && !wr) begin
                if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("rdata", get_rdata(d), e);
                end
            end else begin
                chk("wr_rdata_hold", get_rdata(d), prev);
            end
            held = get_rdata(d);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                wdata[d] = ~wdata[d];
                @(negedge clk);
                chk("held_ready", 32'(get_ready(d)), 32'd1);
                chk("held_rdata", get_rdata(d), held);
            end
        end
        @(posedge clk); #1;
        wen[d] = 1'b0;
        ren[d] = 1'b0;
        @(negedge clk);
        chk("ready_until_edge", 32'(get_ready(d)), 32'(got));
        @(negedge clk);
        chk("ready_fall", 32'(get_ready(d)), 32'd0);
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] data,
                      input logic [3:0] st, input int hold);
        model_write(d, a, data, st);
        access(d, 1'b1, 1'b0, a, data, st, hold);
    endtask

    task automatic rd(input int d, input logic [31:0] a, input logic [31:0] e, input int hold);
        exp_q.push_back(e);
        access(d, 1'b0, 1'b1, a, 32'h0, 4'h0, hold);
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy0 | busy1), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wdata[d] = '0; wstrb[d] = '0; wen[d] = 1'b0; ren[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(get_ready(d)), 32'd0);
            chk("rst_rdata", get_rdata(d), 32'd0);
`ifndef MEM_SRAM_BANK_INIT_CLEAR_EN
            chk("rst_busy", 32'(get_busy(d)), 32'd0);
`endif
        end
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef MEM_SRAM_BANK_INIT_CLEAR_EN
        @(negedge clk);
        chk("clear_busy", 32'(busy0), 32'd1);
        wait_clear("clear_done");
        rd(0, 32'h10, 32'h0, 0);
`endif

        // Write then read, LATENCY = 1
        wr(0, 32'h40, 32'hDEADBEEF, 4'hF, 0);
        rd(0, 32'h40, 32'hDEADBEEF, 0);

        // Byte strobes, then an all-zero strobe
        wr(0, 32'h8, 32'h11223344, 4'hF, 0);
        wr(0, 32'h8, 32'hAABBCCDD, 4'h5, 0);
        rd(0, 32'h8, 32'h11BB33DD, 0);
        wr(0, 32'h8, 32'hFFFFFFFF, 4'h0, 0);
        rd(0, 32'h8, 32'h11BB33DD, 0);

        // Held requests with toggling write data: single access, stable outputs
        rd(0, 32'h40, 32'hDEADBEEF, 6);
        wr(0, 32'h44, 32'h01020304, 4'hF, 6);
        rd(0, 32'h44, 32'h01020304, 0);

        // Both enables high: treated as a write
        model_write(0, 32'h0, 32'h5, 4'hF);
        access(0, 1'b1, 1'b1, 32'h0, 32'h5, 4'hF, 0);
        rd(0, 32'h0, 32'h00000005, 0);

        // Aliasing: 0x1000 maps onto word 0 of a 1024-word bank
        wr(0, 32'h1000, 32'h77665544, 4'hF, 0);
        rd(0, 32'h0, 32'h77665544, 0);
        rd(0, 32'h1000, model[0][0], 2);

        // LATENCY = 4 instance: basic traffic
        wr(1, 32'h20, 32'h12345678, 4'hF, 0);
        rd(1, 32'h20, 32'h12345678, 1);
        wr(1, 32'h24, 32'hA5A5A5A5, 4'hC, 0);
        rd(1, 32'h24, model[1][9] & 32'hFFFF0000 | (32'hA5A5A5A5 & 32'hFFFF0000), 0);

        // Reset in the middle of a write on the LATENCY = 4 instance
        @(posedge clk); #1;
        addr[1] = 32'h20; wdata[1] = 32'hCAFEF00D; wstrb[1] = 4'hF; wen[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        wen[1] = 1'b0;
        @(negedge clk);
        chk("busy_before_rst", 32'(busy1), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_state", 32'(u1.state_q), 32'(ST_IDLE));
        chk("rst_mid_ready", 32'(if1.mem_ready), 32'd0);
        chk("rst_mid_rdata", if1.mem_rdata, 32'd0);
`ifdef MEM_SRAM_BANK_INIT_CLEAR_EN
        wait_clear("clear_done_2");
        rd(1, 32'h20, 32'h0, 0);
`else
        chk("rst_mid_busy", 32'(busy1), 32'd0);
        rd(1, 32'h20, 32'h12345678, 0);
        rd(0, 32'h44, 32'h01020304, 0);
`endif

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
